calc_controller: RTL

Sequencing controller for the simple calculator: steps through operand/opcode entry on `Confirm` pulses, runs the selected arithmetic operation (single-cycle add/sub, iterative multiply and divide), flags divide-by-zero, and holds the result until `Ack`. Sits between the top level (switch/button inputs) and the SSD/LED display logic, which it feeds directly.

---
 rtl/calc_pkg.sv | 44 ++++
 rtl/calc_controller_if.sv | 32 +++
 rtl/calc_iter_unit.sv | 106 ++++++++++
 rtl/calc_controller.sv | 135 +++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// calc_pkg: opcode constants, one-hot state encoding and shared types for
// the calculator sequencing controller.
package calc_pkg;

  localparam int W_DEFAULT = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int NUM_STATES = 10;
  localparam int S_QI       = 9;
  localparam int S_QGET_A   = 8;
  localparam int S_QGET_B   = 7;
  localparam int S_QGET_OP  = 6;
  localparam int S_QADD     = 5;
  localparam int S_QSUB     = 4;
  localparam int S_QMUL     = 3;
  localparam int S_QDIV     = 2;
  localparam int S_QERR     = 1;
  localparam int S_QDONE    = 0;

  typedef enum logic [NUM_STATES-1:0] {
    QI      = 10'b1 << S_QI,
    QGET_A  = 10'b1 << S_QGET_A,
    QGET_B  = 10'b1 << S_QGET_B,
    QGET_OP = 10'b1 << S_QGET_OP,
    QADD    = 10'b1 << S_QADD,
    QSUB    = 10'b1 << S_QSUB,
    QMUL    = 10'b1 << S_QMUL,
    QDIV    = 10'b1 << S_QDIV,
    QERR    = 10'b1 << S_QERR,
    QDONE   = 10'b1 << S_QDONE
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_e;

endpackage
`default_nettype wire

// File: rtl/calc_controller_if.sv
`default_nettype none
// calc_controller_if: operand/opcode entry handshake and result/status bus
// between the calculator top level and the sequencing controller.
interface calc_controller_if
  import calc_pkg::*;
#(
  parameter int W = W_DEFAULT
);
  logic             confirm;
  logic             ack;
  logic [W-1:0]     data_in;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [1:0]       op;
  logic [2*W-1:0]   result;
  logic             neg;
  logic             busy;
  logic             done;
  logic             err;
  logic [9:0]       state;

  modport master (
    output confirm, ack, data_in,
    input  a, b, op, result, neg, busy, done, err, state
  );

  modport slave (
    input  confirm, ack, data_in,
    output a, b, op, result, neg, busy, done, err, state
  );
endinterface
`default_nettype wire

// File: rtl/calc_iter_unit.sv
`default_nettype none
// calc_iter_unit: shared W-cycle engine for unsigned shift-add multiply and
// restoring divide, built around one (W+1)-bit adder/subtractor.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  iter_mode_e       mode_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic             done_o,
  output logic [2*W-1:0]   result_o
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  // hi holds the product high half (mul) or partial remainder (div);
  // lo holds the multiplier being shifted out (mul) or dividend/quotient (div).
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  iter_mode_e       mode_q, mode_d;

  logic             w_sub;
  logic [W:0]       w_x;
  logic [W:0]       w_y;
  logic [W+1:0]     w_sum;
  logic [W-1:0]     w_hi_it;
  logic [W-1:0]     w_lo_it;
  logic             w_last;

  assign w_sub = (mode_q == MODE_DIV);
  assign w_x   = w_sub ? {hi_q, lo_q[W-1]} : {1'b0, hi_q};
  assign w_y   = (w_sub || lo_q[0]) ? {1'b0, opnd_q} : '0;
  // Carry out of the subtract path is the "no borrow" (trial fits) flag.
  assign w_sum = {1'b0, w_x} + {1'b0, w_y ^ {(W+1){w_sub}}} + {{(W+1){1'b0}}, w_sub};

  always_comb begin
    w_hi_it = hi_q;
    w_lo_it = lo_q;
    if (w_sub) begin
      if (w_sum[W+1]) begin
        w_hi_it = w_sum[W-1:0];
        w_lo_it = {lo_q[W-2:0], 1'b1};
      end else begin
        w_hi_it = w_x[W-1:0];
        w_lo_it = {lo_q[W-2:0], 1'b0};
      end
    end else begin
      w_hi_it = w_sum[W:1];
      w_lo_it = {w_sum[0], lo_q[W-1:1]};
    end
  end

  assign w_last   = run_q && (cnt_q == CNT_W'(W - 1));
  assign done_o   = w_last;
  assign result_o = w_sub ? {w_lo_it, w_hi_it} : {w_hi_it, w_lo_it};

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    mode_d = mode_q;
    if (start_i) begin
      hi_d   = '0;
      lo_d   = (mode_i == MODE_DIV) ? a_i : b_i;
      opnd_d = (mode_i == MODE_DIV) ? b_i : a_i;
      cnt_d  = '0;
      run_d  = 1'b1;
      mode_d = mode_i;
    end else if (run_q) begin
      hi_d  = w_hi_it;
      lo_d  = w_lo_it;
      cnt_d = w_last ? '0 : cnt_q + CNT_W'(1);
      run_d = !w_last;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      mode_q <= MODE_MUL;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      mode_q <= mode_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_controller.sv
`default_nettype none
// calc_controller: steps operand/opcode entry on Confirm, runs add/sub inline
// and mul/div on the iterative unit, and holds the answer until Ack.
module calc_controller
  import calc_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  calc_controller_if.slave    bus
);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [2*W-1:0]   result_q, result_d;
  logic             neg_q, neg_d;

  logic             iter_start;
  iter_mode_e       iter_mode;
  logic             iter_done;
  logic [2*W-1:0]   iter_result;

  logic [W:0]       w_add;
  logic [W:0]       w_sub;

  assign w_add = {1'b0, a_q} + {1'b0, b_q};
  assign w_sub = {1'b0, a_q} - {1'b0, b_q};

  calc_iter_unit #(
    .W (W)
  ) u_iter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (iter_start),
    .mode_i   (iter_mode),
    .a_i      (a_q),
    .b_i      (b_q),
    .done_o   (iter_done),
    .result_o (iter_result)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    neg_d      = neg_q;
    iter_start = 1'b0;
    iter_mode  = MODE_MUL;
    case (state_q)
      QI:     if (bus.confirm) state_d = QGET_A;
      QGET_A: if (bus.confirm) begin
        a_d     = bus.data_in;
        state_d = QGET_B;
      end
      QGET_B: if (bus.confirm) begin
        b_d     = bus.data_in;
        state_d = QGET_OP;
      end
      QGET_OP: if (bus.confirm) begin
        op_d = bus.data_in[1:0];
        case (bus.data_in[1:0])
          OP_ADD: state_d = QADD;
          OP_SUB: state_d = QSUB;
          OP_MUL: begin
            state_d    = QMUL;
            iter_start = 1'b1;
            iter_mode  = MODE_MUL;
          end
          default: begin
            // Divide by zero never starts the engine; Result keeps its value.
            if (b_q == '0) begin
              state_d = QERR;
            end else begin
              state_d    = QDIV;
              iter_start = 1'b1;
              iter_mode  = MODE_DIV;
            end
          end
        endcase
      end
      QADD: begin
        result_d = {{(W-1){1'b0}}, w_add};
        neg_d    = 1'b0;
        state_d  = QDONE;
      end
      QSUB: begin
        result_d = {{W{1'b0}}, w_sub[W-1:0]};
        neg_d    = w_sub[W];
        state_d  = QDONE;
      end
      QMUL, QDIV: if (iter_done) begin
        result_d = iter_result;
        neg_d    = 1'b0;
        state_d  = QDONE;
      end
      QDONE, QERR: if (bus.ack) state_d = QI;
      default: state_d = QI;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= QI;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      neg_q    <= neg_d;
    end
  end

  assign bus.a      = a_q;
  assign bus.b      = b_q;
  assign bus.op     = op_q;
  assign bus.result = result_q;
  assign bus.neg    = neg_q;
  assign bus.state  = state_q;
  assign bus.busy   = state_q[S_QADD] | state_q[S_QSUB] | state_q[S_QMUL] | state_q[S_QDIV];
  assign bus.done   = state_q[S_QDONE];
  assign bus.err    = state_q[S_QERR];

endmodule
`default_nettype wire
